// File: rtl/a_unpack_trace_64v48.sv
// a_unpack_trace_64v48
// Expands compressed trace records into a stream of repeated samples.
// A record carries a 48-bit sample value, a 15-bit repeat count and an eq
// flag. The block emits the value count times with a valid/ready handshake.
// When the final repeat retires, the next record can load on the same edge,
// so back-to-back records are emitted with no bubble.
//
// Ports
//   clk_ref         single clock, rising edge
//   rst_n           asynchronous active-low reset
//   flush_i         synchronous abort of the record in progress
//   rec_valid_i     record present on rec_i
//   rec_i[63:0]     [63:16] value, [15:1] repeat count, [0] eq flag
//   rec_ready_o     record accepted this cycle when rec_valid_i is high
//   sample_valid_o  sample_o holds a valid expanded sample
//   sample_o[47:0]  expanded sample value
//   sample_ready_i  downstream takes sample_o this cycle
//   last_o          current sample is the final repeat of its record
//   eq_o            eq flag of the record being expanded
//   err_cnt_o[7:0]  saturating count of malformed records
//
// Build option
//   UNPACK_ERR_CNT_EN  when defined, err_cnt_o counts records whose repeat
//                      count was 0 or above MAX_CNT. When undefined,
//                      err_cnt_o is tied to zero and no counter is built.

module a_unpack_trace_64v48 #(
    parameter logic [14:0] MAX_CNT = 15'h3FFF
) (
    input  logic        clk_ref,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic        rec_valid_i,
    input  logic [63:0] rec_i,
    output logic        rec_ready_o,
    output logic        sample_valid_o,
    output logic [47:0] sample_o,
    input  logic        sample_ready_i,
    output logic        last_o,
    output logic        eq_o,
    output logic [7:0]  err_cnt_o
);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t      state;
    logic [14:0] rem_cnt;

    logic [14:0] raw_cnt;
    logic        cnt_zero;
    logic        cnt_over;
    logic [14:0] load_cnt;
    logic        last_beat;
    logic        accept;
    logic        fire;

    assign raw_cnt  = rec_i[15:1];
    assign cnt_zero = (raw_cnt == 15'd0);
    assign cnt_over = (raw_cnt > MAX_CNT);
    // A zero count still produces one sample; oversized counts are clamped.
    assign load_cnt = cnt_zero ? 15'd1 : (cnt_over ? MAX_CNT : raw_cnt);

    assign last_beat = (state == EMIT) && (rem_cnt == 15'd1);

    // Ready in IDLE, or while the final repeat is retiring so that the next
    // record loads on the same edge. A flush blocks acceptance.
    assign rec_ready_o    = !flush_i &&
                            ((state == IDLE) || (last_beat && sample_ready_i));
    assign sample_valid_o = (state == EMIT);
    assign last_o         = last_beat;

    assign accept = rec_valid_i && rec_ready_o;
    assign fire   = sample_valid_o && sample_ready_i;

    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rem_cnt  <= 15'd0;
            sample_o <= 48'h0;
            eq_o     <= 1'b0;
        end else if (flush_i) begin
            // Any sample handshake this cycle is still delivered; only the
            // remaining repeats are dropped.
            state   <= IDLE;
            rem_cnt <= 15'd0;
        end else if (accept) begin
            state    <= EMIT;
            rem_cnt  <= load_cnt;
            sample_o <= rec_i[63:16];
            eq_o     <= rec_i[0];
        end else if (fire) begin
            rem_cnt <= rem_cnt - 15'd1;
            if (rem_cnt == 15'd1) begin
                state <= IDLE;
            end
        end
    end

`ifdef UNPACK_ERR_CNT_EN
    logic malformed;

    assign malformed = cnt_zero || cnt_over;

    // Counted at acceptance; flush never clears it.
    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_o <= 8'h0;
        end else if (accept && malformed && (err_cnt_o != 8'hFF)) begin
            err_cnt_o <= err_cnt_o + 8'd1;
        end
    end
`else
    assign err_cnt_o = 8'h0;
`endif

endmodule
